sha3_ht_msg_arbiter: RTL and testbench

- Shares one sha3_high_throughput core between NUM_REQ requesters, one message at a time, with round-robin arbitration.
- Sequences the core's input handshake: forwards 64-bit words from the granted requester and stalls them while the core's buffer is full.
- Captures the 512-bit digest and returns it, tagged with the requester id.
- A watchdog aborts a message whose digest never appears.

---
 rtl/sha3_ht_msg_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sha3_ht_msg_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_ht_msg_arbiter.sv
// Round-robin front end that time-shares one sha3_high_throughput core between
// NUM_REQ message sources and returns each 512-bit digest tagged with its owner.
module sha3_ht_msg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [64*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    input  logic [3*NUM_REQ-1:0]    req_byte_num,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [63:0]             core_in,
    output logic                    core_in_ready,
    output logic                    core_is_last,
    output logic [2:0]              core_byte_num,
    input  logic                    core_buffer_full,
    input  logic [511:0]            core_out,
    input  logic                    core_out_ready,
    output logic [511:0]            digest,
    output logic                    digest_valid,
    output logic [2:0]              digest_id,
    output logic                    digest_err,
    input  logic                    digest_ack,
    output logic                    busy
);

    localparam int ID_W = 3;
    localparam int WD_W = 16;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STREAM      = 2'd1,
        WAIT_DIGEST = 2'd2,
        DELIVER     = 2'd3
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [WD_W-1:0]   wd_q;
    logic              out_ready_q;
    logic [511:0]      digest_q;
    logic              digest_valid_q;
    logic [ID_W-1:0]   digest_id_q;
    logic              digest_err_q;
    logic              busy_q;

    logic              arb_found_s;
    logic [ID_W-1:0]   arb_idx_s;
    logic [ID_W-1:0]   rr_next_s;
    logic              sel_valid_s;
    logic              sel_last_s;
    logic [63:0]       sel_data_s;
    logic [2:0]        sel_byte_num_s;
    logic              xfer_s;
    logic              out_edge_s;
    logic              wd_expired_s;

    // Circular search for the first valid requester starting at rr_ptr_q.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                logic hit;
                hit         = req_valid[i] && (((int'(rr_ptr_q) + k) % NUM_REQ) == i);
                arb_idx_s   = (!arb_found_s && hit) ? ID_W'(i) : arb_idx_s;
                arb_found_s = arb_found_s | hit;
            end
        end
        rr_next_s = (int'(arb_idx_s) == NUM_REQ - 1) ? {ID_W{1'b0}} : (arb_idx_s + ID_W'(1));
    end

    // AND-OR mux of the granted requester's word and sideband.
    always_comb begin
        sel_valid_s    = 1'b0;
        sel_last_s     = 1'b0;
        sel_data_s     = 64'd0;
        sel_byte_num_s = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic g;
            g              = (grant_q == ID_W'(i));
            sel_valid_s    = sel_valid_s | (g & req_valid[i]);
            sel_last_s     = sel_last_s | (g & req_last[i]);
            sel_data_s     = sel_data_s | ({64{g}} & req_data[64*i +: 64]);
            sel_byte_num_s = sel_byte_num_s | ({3{g}} & req_byte_num[3*i +: 3]);
        end
    end

    assign xfer_s       = (state_q == STREAM) & sel_valid_s & ~core_buffer_full;
    assign out_edge_s   = core_out_ready & ~out_ready_q;
    assign wd_expired_s = (wd_q == WD_W'(TIMEOUT));

    // Core input handshake is live only while streaming; zero otherwise.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (state_q == STREAM) begin
            core_in_ready = xfer_s;
            core_in       = sel_data_s;
            core_is_last  = sel_last_s;
            core_byte_num = sel_last_s ? sel_byte_num_s : 3'd0;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = xfer_s & (grant_q == ID_W'(i));
            end
        end else begin
            core_in_ready = 1'b0;
            core_in       = 64'd0;
            core_is_last  = 1'b0;
            core_byte_num = 3'd0;
        end
    end

    // Message sequencer with registered digest outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= {ID_W{1'b0}};
            rr_ptr_q       <= {ID_W{1'b0}};
            wd_q           <= {WD_W{1'b0}};
            out_ready_q    <= 1'b0;
            digest_q       <= 512'd0;
            digest_valid_q <= 1'b0;
            digest_id_q    <= {ID_W{1'b0}};
            digest_err_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            out_ready_q <= core_out_ready;
            case (state_q)
                IDLE: begin
                    if (arb_found_s) begin
                        grant_q  <= arb_idx_s;
                        rr_ptr_q <= rr_next_s;
                        busy_q   <= 1'b1;
                        state_q  <= STREAM;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (xfer_s && sel_last_s) begin
                        wd_q    <= {WD_W{1'b0}};
                        state_q <= WAIT_DIGEST;
                    end else begin
                        state_q <= STREAM;
                    end
                end
                WAIT_DIGEST: begin
                    // A rising out_ready takes priority over an expiring watchdog.
                    if (out_edge_s) begin
                        digest_q       <= core_out;
                        digest_err_q   <= 1'b0;
                        digest_id_q    <= grant_q;
                        digest_valid_q <= 1'b1;
                        state_q        <= DELIVER;
                    end else if (wd_expired_s) begin
                        digest_q       <= 512'd0;
                        digest_err_q   <= 1'b1;
                        digest_id_q    <= grant_q;
                        digest_valid_q <= 1'b1;
                        state_q        <= DELIVER;
                    end else begin
                        wd_q           <= wd_q + WD_W'(1);
                    end
                end
                DELIVER: begin
                    if (digest_ack) begin
                        digest_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        digest_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign digest_id    = digest_id_q;
    assign digest_err   = digest_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sha3_ht_msg_arbiter.sv
// Directed bench for sha3_ht_msg_arbiter: streaming, backpressure, round-robin,
// watchdog aborts, edge/timeout collision and asynchronous reset.
module tb_sha3_ht_msg_arbiter;

    localparam int NR = 4;
    localparam int TO = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [64*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [3*NR-1:0] req_byte_num;
    logic [NR-1:0]   req_ready;
    logic [63:0]     core_in;
    logic            core_in_ready;
    logic            core_is_last;
    logic [2:0]      core_byte_num;
    logic            core_buffer_full;
    logic [511:0]    core_out;
    logic            core_out_ready;
    logic [511:0]    digest;
    logic            digest_valid;
    logic [2:0]      digest_id;
    logic            digest_err;
    logic            digest_ack;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] mon_q[$];

    sha3_ht_msg_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_byte_num(req_byte_num), .req_ready(req_ready),
        .core_in(core_in), .core_in_ready(core_in_ready), .core_is_last(core_is_last),
        .core_byte_num(core_byte_num), .core_buffer_full(core_buffer_full),
        .core_out(core_out), .core_out_ready(core_out_ready),
        .digest(digest), .digest_valid(digest_valid), .digest_id(digest_id),
        .digest_err(digest_err), .digest_ack(digest_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every word the core actually accepts.
    always @(posedge clk) begin
        if (core_in_ready) mon_q.push_back(core_in);
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic [63:0] d, input logic l, input logic [2:0] bn);
        req_valid[r]          = 1'b1;
        req_data[64*r +: 64]  = d;
        req_last[r]           = l;
        req_byte_num[3*r +: 3] = bn;
    endtask

    task automatic idle_reqs();
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic ack();
        digest_ack = 1'b1;
        step();
        digest_ack = 1'b0;
    endtask

    initial begin
        logic [511:0] dig1, dig2, dig5, dig6, digs;
        logic [63:0]  bp_w [4];
        logic [63:0]  rr_w [4];
        int           rr_exp [6];
        int           base;
        logic [3:0]   onehot;

        dig1 = {8{64'hABCD_EF01_2345_6789}};
        dig2 = {8{64'h0F0F_1234_5678_9ABC}};
        dig5 = {8{64'h5555_AAAA_C3C3_3C3C}};
        dig6 = {8{64'h6666_0000_6666_FFFF}};
        digs = {8{64'hDEAD_BEEF_CAFE_F00D}};
        bp_w = '{64'hA1A1_A1A1_A1A1_A1A1, 64'hA2A2_A2A2_A2A2_A2A2,
                 64'hA3A3_A3A3_A3A3_A3A3, 64'hA4A4_A4A4_A4A4_A4A4};
        rr_w = '{64'h0000_0000_0000_00F0, 64'h0000_0000_0000_00F1,
                 64'h0000_0000_0000_00F2, 64'h0000_0000_0000_00F3};
        rr_exp = '{0, 1, 3, 0, 1, 3};

        reset = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0; req_byte_num = '0;
        core_buffer_full = 1'b0; core_out = '0; core_out_ready = 1'b0; digest_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_dvalid", digest_valid, 1'b0);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_core_in_ready", core_in_ready, 1'b0);
        chk("rst_digest", digest, 512'd0);
        reset = 1'b0;

        // Single three-word message from requester 0
        drive(0, 64'h1111_1111_1111_1111, 1'b0, 3'd0);
        #1;
        chk("t1_arb_no_ready", req_ready, 4'b0000);
        chk("t1_arb_busy", busy, 1'b0);
        step();
        chk("t1_w1_in_ready", core_in_ready, 1'b1);
        chk("t1_w1_data", core_in, 64'h1111_1111_1111_1111);
        chk("t1_w1_last", core_is_last, 1'b0);
        chk("t1_w1_req_ready", req_ready, 4'b0001);
        chk("t1_busy", busy, 1'b1);
        step();
        drive(0, 64'h2222_2222_2222_2222, 1'b0, 3'd5);
        #1;
        chk("t1_w2_data", core_in, 64'h2222_2222_2222_2222);
        chk("t1_w2_bn_forced0", core_byte_num, 3'd0);
        step();
        drive(0, 64'h3333_3333_3333_3333, 1'b1, 3'd5);
        #1;
        chk("t1_w3_data", core_in, 64'h3333_3333_3333_3333);
        chk("t1_w3_last", core_is_last, 1'b1);
        chk("t1_w3_bn", core_byte_num, 3'd5);
        step();
        idle_reqs();
        #1;
        chk("t1_wait_in_ready", core_in_ready, 1'b0);
        chk("t1_wait_dvalid", digest_valid, 1'b0);
        core_out = dig1;
        core_out_ready = 1'b1;
        step();
        chk("t1_dvalid", digest_valid, 1'b1);
        chk("t1_digest", digest, dig1);
        chk("t1_id", digest_id, 3'd0);
        chk("t1_err", digest_err, 1'b0);
        core_out_ready = 1'b0;
        core_out = '0;
        step();
        step();
        chk("t1_hold_valid", digest_valid, 1'b1);
        chk("t1_hold_digest", digest, dig1);
        ack();
        chk("t1_ack_dvalid", digest_valid, 1'b0);
        chk("t1_ack_busy", busy, 1'b0);

        // Backpressure: buffer_full for 4 cycles after the first word
        base = mon_q.size();
        drive(0, bp_w[0], 1'b0, 3'd0);
        step();
        step();
        drive(0, bp_w[1], 1'b0, 3'd0);
        core_buffer_full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t2_stall_in_ready", core_in_ready, 1'b0);
            chk("t2_stall_req_ready", req_ready, 4'b0000);
            step();
        end
        core_buffer_full = 1'b0;
        #1;
        chk("t2_resume_in_ready", core_in_ready, 1'b1);
        step();
        drive(0, bp_w[2], 1'b0, 3'd0);
        step();
        drive(0, bp_w[3], 1'b1, 3'd7);
        step();
        idle_reqs();
        chk("t2_word_count", 32'(mon_q.size() - base), 32'd4);
        for (int c = 0; c < 4; c++) begin
            if (base + c < mon_q.size()) chk("t2_word", mon_q[base + c], bp_w[c]);
            else chk("t2_word_missing", 1'b0, 1'b1);
        end
        core_out = dig2;
        core_out_ready = 1'b1;
        step();
        chk("t2_digest", digest, dig2);
        core_out_ready = 1'b0;
        ack();

        // Watchdog abort from requester 3, out_ready never rises
        drive(3, 64'h7777_0000_0000_0001, 1'b0, 3'd0);
        step();
        chk("t3_grant", req_ready, 4'b1000);
        step();
        drive(3, 64'h7777_0000_0000_0002, 1'b1, 3'd3);
        step();
        idle_reqs();
        repeat (TO) step();
        chk("t3_pre_timeout", digest_valid, 1'b0);
        step();
        chk("t3_dvalid", digest_valid, 1'b1);
        chk("t3_err", digest_err, 1'b1);
        chk("t3_digest_zero", digest, 512'd0);
        chk("t3_id", digest_id, 3'd3);
        ack();

        // Stale out_ready already high before the digest wait
        core_out = digs;
        core_out_ready = 1'b1;
        drive(3, 64'h7777_0000_0000_0003, 1'b1, 3'd2);
        step();
        step();
        idle_reqs();
        repeat (TO) step();
        chk("t3s_pre_timeout", digest_valid, 1'b0);
        step();
        chk("t3s_dvalid", digest_valid, 1'b1);
        chk("t3s_err", digest_err, 1'b1);
        chk("t3s_digest_zero", digest, 512'd0);
        core_out_ready = 1'b0;
        ack();

        // Round robin between requesters 0, 1 and 3 with one-word messages
        drive(0, rr_w[0], 1'b1, 3'd1);
        drive(1, rr_w[1], 1'b1, 3'd2);
        drive(3, rr_w[3], 1'b1, 3'd4);
        for (int m = 0; m < 6; m++) begin
            step();
            onehot = 4'b0001 << rr_exp[m];
            chk("t4_grant", req_ready, onehot);
            chk("t4_data", core_in, rr_w[rr_exp[m]]);
            step();
            core_out = {8{64'(m)}};
            core_out_ready = 1'b1;
            step();
            chk("t4_id", digest_id, rr_exp[m][2:0]);
            core_out_ready = 1'b0;
            ack();
        end
        idle_reqs();

        // One-word message, out_ready rises on the watchdog==TIMEOUT cycle
        drive(1, 64'hC0C0_C0C0_C0C0_C0C0, 1'b1, 3'd0);
        step();
        chk("t5_grant", req_ready, 4'b0010);
        chk("t5_last", core_is_last, 1'b1);
        chk("t5_bn", core_byte_num, 3'd0);
        step();
        idle_reqs();
        repeat (TO) step();
        core_out = dig5;
        core_out_ready = 1'b1;
        #1;
        chk("t5_pre_edge", digest_valid, 1'b0);
        step();
        chk("t5_dvalid", digest_valid, 1'b1);
        chk("t5_err", digest_err, 1'b0);
        chk("t5_digest", digest, dig5);
        chk("t5_id", digest_id, 3'd1);
        core_out_ready = 1'b0;
        ack();

        // Asynchronous reset after word 2 of a 4-word message from requester 2
        drive(2, 64'hD001_D001_D001_D001, 1'b0, 3'd0);
        step();
        step();
        drive(2, 64'hD002_D002_D002_D002, 1'b0, 3'd0);
        step();
        drive(2, 64'hD003_D003_D003_D003, 1'b0, 3'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_in_ready", core_in_ready, 1'b0);
        chk("t6_req_ready", req_ready, 4'b0000);
        chk("t6_core_in", core_in, 64'd0);
        chk("t6_dvalid", digest_valid, 1'b0);
        idle_reqs();
        step();
        step();
        reset = 1'b0;
        drive(2, 64'hE222_E222_E222_E222, 1'b1, 3'd6);
        drive(3, 64'hE333_E333_E333_E333, 1'b1, 3'd1);
        step();
        chk("t6_post_grant", req_ready, 4'b0100);
        chk("t6_post_data", core_in, 64'hE222_E222_E222_E222);
        chk("t6_post_bn", core_byte_num, 3'd6);
        step();
        idle_reqs();
        core_out = dig6;
        core_out_ready = 1'b1;
        step();
        chk("t6_post_dvalid", digest_valid, 1'b1);
        chk("t6_post_digest", digest, dig6);
        chk("t6_post_id", digest_id, 3'd2);
        chk("t6_post_err", digest_err, 1'b0);
        core_out_ready = 1'b0;
        ack();
        chk("t6_final_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
